// File: rtl/game_sequencer_pkg.sv
// Shared definitions for the tile-game sequencer: state codes and default widths.
package game_sequencer_pkg;

  localparam int unsigned DefOffsetW = 6;
  localparam int unsigned DefLevelW  = 3;

  // Encodings are fixed because current_state is shown on the debug display.
  typedef enum logic [3:0] {
    StIdle        = 4'd0,
    StResetScreen = 4'd1,
    StDetectEdge  = 4'd2,
    StEdgeStuff   = 4'd3,
    StDraw        = 4'd4,
    StWaitNext    = 4'd5,
    StNextRow     = 4'd6,
    StPaused      = 4'd7,
    StGameOver    = 4'd8
  } state_e;

endpackage

// File: rtl/game_sequencer_level_tracker.sv
// Counts completed tile rows and ramps a saturating speed level every LEVEL_ROWS rows.
module game_sequencer_level_tracker #(
  parameter int unsigned LEVEL_ROWS = 16,
  parameter int unsigned NUM_LEVELS = 8,
  parameter int unsigned LEVEL_W    = 3
) (
  input  logic               clock,
  input  logic               resetn,
  input  logic               row_tick,
  output logic [LEVEL_W-1:0] level
);

  // Keep the counter at least one bit wide so LEVEL_ROWS=1 still elaborates.
  localparam int unsigned RowW = (LEVEL_ROWS > 1) ? $clog2(LEVEL_ROWS) : 1;

  logic [RowW-1:0]    row_cnt_q, row_cnt_d;
  logic [LEVEL_W-1:0] level_q, level_d;

  // Row counter wraps at LEVEL_ROWS-1 and bumps the level, which saturates at the top.
  always_comb begin
    row_cnt_d = row_cnt_q;
    level_d   = level_q;
    if (row_tick) begin
      if (row_cnt_q == RowW'(LEVEL_ROWS - 1)) begin
        row_cnt_d = '0;
        if (level_q != LEVEL_W'(NUM_LEVELS - 1)) begin
          level_d = level_q + LEVEL_W'(1);
        end
      end else begin
        row_cnt_d = row_cnt_q + RowW'(1);
      end
    end
  end

  // Synchronous active-low reset clears both counters.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      row_cnt_q <= '0;
      level_q   <= '0;
    end else begin
      row_cnt_q <= row_cnt_d;
      level_q   <= level_d;
    end
  end

  assign level = level_q;

endmodule

// File: rtl/game_sequencer.sv
// Top-level tile-game sequencer: master FSM, scroll offset and speed level.
module game_sequencer
  import game_sequencer_pkg::*;
#(
  parameter int unsigned OFFSET_W   = DefOffsetW,
  parameter int unsigned ROW_PITCH  = 40,
  parameter int unsigned LEVEL_ROWS = 16,
  parameter int unsigned NUM_LEVELS = 8,
  parameter int unsigned LEVEL_W    = DefLevelW
) (
  input  logic                clock,
  input  logic                resetn,
  input  logic                reset_screen_done,
  input  logic                draw_done,
  input  logic                wait_done,
  input  logic                miss,
  input  logic                pause,
  output logic                reset_screen_go,
  output logic                draw_go,
  output logic                wait_go,
  output logic                edge_go,
  output logic                offset_increase,
  output logic [OFFSET_W-1:0] offset,
  output logic [LEVEL_W-1:0]  level,
  output logic                game_over,
  output logic [3:0]          current_state
);

  state_e              state_q, state_d;
  logic [OFFSET_W-1:0] offset_q, offset_d;
  logic                row_tick;

  // Next-state and offset update; unlisted conditions hold.
  always_comb begin
    state_d  = state_q;
    offset_d = offset_q;
    row_tick = 1'b0;
    unique case (state_q)
      StIdle: ;
      StResetScreen: begin
        if (reset_screen_done) state_d = StDetectEdge;
      end
      StDetectEdge: begin
        state_d = (offset_q == OFFSET_W'(ROW_PITCH)) ? StEdgeStuff : StDraw;
      end
      StEdgeStuff: begin
        if (miss) begin
          state_d = StGameOver;
        end else begin
          state_d  = StDraw;
          offset_d = '0;
          row_tick = 1'b1;
        end
      end
      StDraw: begin
        if (draw_done) state_d = StWaitNext;
      end
      StWaitNext: begin
        // A finished wait beats a simultaneous pause request.
        if (wait_done)  state_d = StNextRow;
        else if (pause) state_d = StPaused;
      end
      StNextRow: begin
        state_d  = StDetectEdge;
        offset_d = offset_q + OFFSET_W'(1);
      end
      StPaused: begin
        if (!pause) state_d = StWaitNext;
      end
      StGameOver: ;
      default: state_d = StIdle;
    endcase
  end

  // State and offset registers; reset forces a fresh screen clear from anywhere.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q  <= StResetScreen;
      offset_q <= '0;
    end else begin
      state_q  <= state_d;
      offset_q <= offset_d;
    end
  end

  game_sequencer_level_tracker #(
    .LEVEL_ROWS (LEVEL_ROWS),
    .NUM_LEVELS (NUM_LEVELS),
    .LEVEL_W    (LEVEL_W)
  ) u_level_tracker (
    .clock    (clock),
    .resetn   (resetn),
    .row_tick (row_tick),
    .level    (level)
  );

  // Moore outputs; handshakes and game_over are forced low while reset is held.
  always_comb begin
    reset_screen_go = resetn && (state_q == StResetScreen);
    draw_go         = resetn && (state_q == StDraw);
    wait_go         = resetn && (state_q == StWaitNext);
    edge_go         = resetn && (state_q == StEdgeStuff);
    offset_increase = resetn && (state_q == StNextRow);
    game_over       = resetn && (state_q == StGameOver);
  end

  assign offset        = offset_q;
  assign current_state = state_q;

endmodule
